// File: rtl/esn_step_ctrl.sv
// rtl/esn_step_ctrl.sv - sequences one echo-state-network reservoir frame over a shared saturating accumulator
// Cells are processed one at a time; new states land in a shadow bank and commit together at frame end.
module esn_step_ctrl #(
  parameter int NUM_CELLS  = 4,
  parameter int NUM_STEPS  = 3,
  parameter int data_width = 3,
  localparam int CW = (NUM_CELLS > 1) ? $clog2(NUM_CELLS) : 1
) (
  input  logic                              iClk,
  input  logic                              iRst_n,
  input  logic                              iStart,
  input  logic [NUM_CELLS*NUM_STEPS-1:0]    iWeights,
  input  logic [data_width-1:0]             iSum,
  output logic                              oReady,
  output logic                              oEn,
  output logic                              oBitU,
  output logic [data_width-1:0]             oTerm,
  output logic                              oAccRst_n,
  output logic [CW-1:0]                     oCell,
  output logic [NUM_CELLS*data_width-1:0]   oState,
  output logic                              oDone
);

  localparam int NW = NUM_CELLS * NUM_STEPS;
  localparam int SW = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
  localparam int IW = (NW > 1) ? $clog2(NW) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ACC,
    S_CAPTURE,
    S_COMMIT
  } state_t;

  state_t                r_fsm;
  logic [NW-1:0]         r_weights;
  logic [CW-1:0]         r_cell;
  logic [SW-1:0]         r_step;
  logic [data_width-1:0] r_bank   [NUM_CELLS];
  logic [data_width-1:0] r_shadow [NUM_CELLS];
  logic                  r_en;
  logic                  r_bitu;
  logic [data_width-1:0] r_term;
  logic                  r_acc_rst_n;
  logic                  r_done;

  logic [CW-1:0]         w_prev_cell;
  logic [IW-1:0]         w_idx_first;
  logic [IW-1:0]         w_idx_next;
  logic                  w_last_step;
  logic                  w_last_cell;

  // Ring neighbour: cell 0 reads the last cell.
  assign w_prev_cell = (r_cell == '0) ? CW'(NUM_CELLS - 1) : r_cell - 1'b1;
  assign w_idx_first = IW'(int'(r_cell) * NUM_STEPS);
  assign w_idx_next  = IW'(int'(r_cell) * NUM_STEPS + int'(r_step) + 1);
  assign w_last_step = (r_step == SW'(NUM_STEPS - 1));
  assign w_last_cell = (r_cell == CW'(NUM_CELLS - 1));

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_fsm       <= S_IDLE;
      r_weights   <= '0;
      r_cell      <= '0;
      r_step      <= '0;
      r_en        <= 1'b0;
      r_bitu      <= 1'b0;
      r_term      <= '0;
      r_acc_rst_n <= 1'b0;
      r_done      <= 1'b0;
      for (int c = 0; c < NUM_CELLS; c++) begin
        r_bank[c]   <= '0;
        r_shadow[c] <= '0;
      end
    end else begin
      r_done      <= 1'b0;
      r_en        <= 1'b0;
      r_acc_rst_n <= 1'b1;
      case (r_fsm)
        S_IDLE: begin
          if (iStart) begin
            r_weights   <= iWeights;
            r_cell      <= '0;
            r_acc_rst_n <= 1'b0;
            r_fsm       <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          r_step <= '0;
          r_en   <= 1'b1;
          r_bitu <= r_weights[w_idx_first];
          r_term <= r_bank[w_prev_cell];
          r_fsm  <= S_ACC;
        end
        S_ACC: begin
          if (w_last_step) begin
            r_fsm <= S_CAPTURE;
          end else begin
            r_step <= r_step + 1'b1;
            r_en   <= 1'b1;
            r_bitu <= r_weights[w_idx_next];
          end
        end
        S_CAPTURE: begin
          r_shadow[r_cell] <= iSum;
          if (w_last_cell) begin
            r_fsm <= S_COMMIT;
          end else begin
            r_cell      <= r_cell + 1'b1;
            r_acc_rst_n <= 1'b0;
            r_fsm       <= S_CLEAR;
          end
        end
        S_COMMIT: begin
          for (int c = 0; c < NUM_CELLS; c++) begin
            r_bank[c] <= r_shadow[c];
          end
          r_done <= 1'b1;
          r_fsm  <= S_IDLE;
        end
        default: r_fsm <= S_IDLE;
      endcase
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_CELLS; g++) begin : g_state
      assign oState[g*data_width +: data_width] = r_bank[g];
    end
  endgenerate

  assign oReady    = (r_fsm == S_IDLE);
  assign oEn       = r_en;
  assign oBitU     = r_bitu;
  assign oTerm     = r_term;
  assign oAccRst_n = r_acc_rst_n;
  assign oCell     = r_cell;
  assign oDone     = r_done;

endmodule

// File: tb/tb_esn_step_ctrl.sv
// tb/tb_esn_step_ctrl.sv - randomized self-checking bench for esn_step_ctrl with a behavioural accumulator
module tb_esn_step_ctrl;
  localparam int NC = 4;
  localparam int NS = 3;
  localparam int DW = 3;
  localparam int FRAME = NC * (NS + 2) + 1;

  logic              iClk = 1'b0;
  logic              iRst_n;
  logic              iStart;
  logic [NC*NS-1:0]  iWeights;
  logic [DW-1:0]     w_sum;
  logic              oReady, oEn, oBitU, oAccRst_n, oDone;
  logic [DW-1:0]     oTerm;
  logic [1:0]        oCell;
  logic [NC*DW-1:0]  oState;

  int total = 0;
  int bad = 0;

  esn_step_ctrl #(.NUM_CELLS(NC), .NUM_STEPS(NS), .data_width(DW)) dut (
    .iClk(iClk), .iRst_n(iRst_n), .iStart(iStart), .iWeights(iWeights),
    .iSum(w_sum), .oReady(oReady), .oEn(oEn), .oBitU(oBitU), .oTerm(oTerm),
    .oAccRst_n(oAccRst_n), .oCell(oCell), .oState(oState), .oDone(oDone)
  );

  always #5 iClk = ~iClk;

  // Saturating up/down step: a neighbour term at the limit in the step direction freezes the sum.
  function automatic logic [DW-1:0] acc_step(input logic [DW-1:0] s, input logic b, input logic [DW-1:0] t);
    if (b) return (t != 3'b011 && s != 3'b011) ? s + 3'd1 : s;
    else   return (t != 3'b100 && s != 3'b100) ? s - 3'd1 : s;
  endfunction

  always @(posedge iClk or negedge oAccRst_n) begin
    if (!oAccRst_n) w_sum <= '0;
    else if (oEn)   w_sum <= acc_step(w_sum, oBitU, oTerm);
  end

  // Frame model: k counts cycles since accept (0 = idle), outputs derive from k arithmetically.
  int              k;
  logic            m_done, m_seen;
  logic [NC*NS-1:0] m_w;
  logic [DW-1:0]   m_st [NC];

  function automatic logic [DW-1:0] next_state(input int c);
    logic [DW-1:0] s;
    s = '0;
    for (int st = 0; st < NS; st++) s = acc_step(s, m_w[c*NS+st], m_st[(c+NC-1)%NC]);
    return s;
  endfunction

  function automatic logic [NC*DW-1:0] m_pack();
    logic [NC*DW-1:0] r;
    for (int c = 0; c < NC; c++) r[c*DW +: DW] = m_st[c];
    return r;
  endfunction

  always @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      k <= 0; m_done <= 1'b0; m_seen <= 1'b0; m_w <= '0;
      for (int c = 0; c < NC; c++) m_st[c] <= '0;
    end else begin
      m_seen <= 1'b1;
      m_done <= 1'b0;
      if (k == 0) begin
        if (iStart) begin k <= 1; m_w <= iWeights; end
      end else if (k == FRAME) begin
        k <= 0;
        m_done <= 1'b1;
        for (int c = 0; c < NC; c++) m_st[c] <= next_state(c);
      end else begin
        k <= k + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  int  c_cl, c_ph;
  logic c_busy, c_acc;
  always @(negedge iClk) begin
    c_busy = (k != 0);
    c_cl   = (k - 1) / (NS + 2);
    c_ph   = (k - 1) % (NS + 2);
    c_acc  = c_busy && k < FRAME && c_ph >= 1 && c_ph <= NS;
    chk("ready", 32'(oReady), 32'(!c_busy));
    chk("done", 32'(oDone), 32'(m_done));
    chk("state", 32'(oState), 32'(m_pack()));
    chk("acc_rst_n", 32'(oAccRst_n), 32'(m_seen && !(c_busy && k < FRAME && c_ph == 0)));
    chk("en", 32'(oEn), 32'(c_acc));
    if (c_busy && k < FRAME) chk("cell", 32'(oCell), 32'(c_cl));
    if (c_acc) begin
      chk("bitu", 32'(oBitU), 32'(m_w[c_cl*NS + c_ph - 1]));
      chk("term", 32'(oTerm), 32'(m_st[(c_cl+NC-1)%NC]));
    end
  end

  task automatic run_frame(input logic [NC*NS-1:0] w, input bit spam, output int lat);
    bit got;
    got = 1'b0;
    lat = 0;
    @(negedge iClk);
    iWeights = w;
    iStart = 1'b1;
    @(posedge iClk);
    @(negedge iClk);
    iStart = spam;
    for (int n = 1; n <= 40 && !got; n++) begin
      @(posedge iClk);
      lat = n;
      @(negedge iClk);
      iStart = spam && (n == 11);
      iWeights = (NC*NS)'($urandom);
      if (oDone) got = 1'b1;
    end
    iStart = 1'b0;
    if (!got) chk("done_timeout", 32'(got), 32'd1);
  endtask

  int lat;
  initial begin
    iRst_n = 1'b0; iStart = 1'b0; iWeights = '0;
    repeat (3) @(negedge iClk);
    chk("acc_rst_in_reset", 32'(oAccRst_n), 32'd0);
    #2 iRst_n = 1'b1;
    @(negedge iClk);
    chk("acc_rst_after_edge", 32'(oAccRst_n), 32'd1);
    repeat (20) @(negedge iClk);

    run_frame('1, 1'b0, lat);
    chk("latency", 32'(lat), 32'd21);
    chk("frame1_state", 32'(oState), 32'h6DB);
    run_frame('1, 1'b0, lat);
    chk("frame2_state", 32'(oState), 32'h000);
    run_frame(12'hFF8, 1'b0, lat);
    chk("frame3_state", 32'(oState), 32'h6DD);
    run_frame(12'(($urandom)), 1'b1, lat);
    chk("spam_latency", 32'(lat), 32'd21);

    @(negedge iClk);
    iWeights = 12'(($urandom)); iStart = 1'b1;
    @(posedge iClk);
    @(negedge iClk);
    iStart = 1'b0;
    repeat (12) @(posedge iClk);
    #2 iRst_n = 1'b0;
    #1;
    chk("rst_en", 32'(oEn), 32'd0);
    chk("rst_state", 32'(oState), 32'd0);
    chk("rst_ready", 32'(oReady), 32'd1);
    chk("rst_acc", 32'(oAccRst_n), 32'd0);
    repeat (2) @(negedge iClk);
    #2 iRst_n = 1'b1;
    repeat (3) @(negedge iClk);
    run_frame(12'(($urandom)), 1'b0, lat);
    chk("post_rst_latency", 32'(lat), 32'd21);

    for (int i = 0; i < 6; i++) begin
      run_frame(12'(($urandom)), 1'($urandom), lat);
      repeat ($urandom_range(0, 2)) @(negedge iClk);
    end
    repeat (3) @(negedge iClk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
